// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC capture scheduler.
package adc_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } sched_state_e;

    typedef enum logic [1:0] {
        TRIG_IMMEDIATE = 2'd0,
        TRIG_SOFTWARE  = 2'd1,
        TRIG_EXT_RISE  = 2'd2,
        TRIG_EXT_FALL  = 2'd3
    } trig_mode_e;

    localparam int unsigned MIN_PERIOD_DEFAULT = 200;
    localparam int unsigned PERIOD_W           = 24;
    localparam int unsigned SAMPLES_W          = 16;

    function automatic logic [PERIOD_W-1:0] clamp_period(
        input logic [PERIOD_W-1:0] req,
        input logic [PERIOD_W-1:0] floor
    );
        return (req < floor) ? floor : req;
    endfunction

endpackage

// File: rtl/adc_capture_sched_trig_sync.sv
// Two-flop synchroniser for the external trigger pin with registered
// rise/fall pulses (pin-to-pulse latency of three clocks).
module trig_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic hist_q;
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            hist_q <= sync_q;
            rise_q <= sync_q & ~hist_q;
            fall_q <= ~sync_q & hist_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/adc_capture_sched.sv
// Capture scheduler: arms on start, waits for a trigger, then issues
// periodic conversion requests and drains the last one before finishing.
module adc_capture_sched
    import adc_sched_pkg::*;
#(
    parameter int unsigned P_MIN_PERIOD   = MIN_PERIOD_DEFAULT,
    parameter int unsigned P_DONE_TIMEOUT = 4096
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic [PERIOD_W-1:0]  i_cfg_period,
    input  logic [SAMPLES_W-1:0] i_cfg_samples,
    input  logic [1:0]           i_cfg_trig_mode,
    input  logic                 i_sw_trig,
    input  logic                 i_external_trig,
    output logic                 o_conv_req,
    input  logic                 i_conv_done,
    output logic                 o_armed,
    output logic                 o_running,
    output logic                 o_done,
    output logic [SAMPLES_W-1:0] o_sample_idx,
    output logic                 o_overrun,
    output logic                 o_aborted
);

    localparam int unsigned TO_W = (P_DONE_TIMEOUT > 1) ? $clog2(P_DONE_TIMEOUT) : 1;
    localparam logic [TO_W-1:0]     TO_LAST    = TO_W'(P_DONE_TIMEOUT - 1);
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(P_MIN_PERIOD);

    sched_state_e         state_q,   state_d;
    logic [PERIOD_W-1:0]  period_q,  period_d;
    logic [SAMPLES_W-1:0] samples_q, samples_d;
    trig_mode_e           mode_q,    mode_d;
    logic [PERIOD_W-1:0]  slot_q,    slot_d;
    logic [TO_W-1:0]      flush_q,   flush_d;
    logic                 pend_q,    pend_d;
    logic [SAMPLES_W-1:0] idx_q,     idx_d;
    logic                 overrun_q, overrun_d;
    logic                 aborted_q, aborted_d;
    logic                 done_q,    done_d;
    logic                 conv_req;
    logic                 trig_hit;
    logic                 ext_rise;
    logic                 ext_fall;

    trig_sync_edge u_trig_sync (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .async_i (i_external_trig),
        .rise_o  (ext_rise),
        .fall_o  (ext_fall)
    );

    always_comb begin
        unique case (mode_q)
            TRIG_IMMEDIATE: trig_hit = 1'b1;
            TRIG_SOFTWARE:  trig_hit = i_sw_trig;
            TRIG_EXT_RISE:  trig_hit = ext_rise;
            TRIG_EXT_FALL:  trig_hit = ext_fall;
            default:        trig_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        samples_d = samples_q;
        mode_d    = mode_q;
        slot_d    = slot_q;
        flush_d   = flush_q;
        pend_d    = pend_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        aborted_d = aborted_q;
        done_d    = 1'b0;
        conv_req  = 1'b0;

        // Completion is applied before a new request so a coincident done frees the slot.
        if (i_conv_done) begin
            pend_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (i_start && !i_stop) begin
                    period_d  = clamp_period(i_cfg_period, MIN_PERIOD);
                    samples_d = i_cfg_samples;
                    mode_d    = trig_mode_e'(i_cfg_trig_mode);
                    idx_d     = '0;
                    overrun_d = 1'b0;
                    aborted_d = 1'b0;
                    pend_d    = 1'b0;
                    state_d   = S_ARM;
                end
            end

            S_ARM: begin
                if (i_stop) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (trig_hit) begin
                    slot_d  = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (i_stop) begin
                    aborted_d = 1'b1;
                    flush_d   = '0;
                    state_d   = S_FLUSH;
                end else begin
                    slot_d = (slot_q == period_q - PERIOD_W'(1)) ? '0 : slot_q + PERIOD_W'(1);
                    if (slot_q == '0) begin
                        if (pend_q && !i_conv_done) begin
                            overrun_d = 1'b1;
                        end else begin
                            conv_req = 1'b1;
                            pend_d   = 1'b1;
                            idx_d    = idx_q + SAMPLES_W'(1);
                            if ((samples_q != '0) && (idx_d == samples_q)) begin
                                flush_d = '0;
                                state_d = S_FLUSH;
                            end
                        end
                    end
                end
            end

            S_FLUSH: begin
                if (!pend_q || i_conv_done) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (flush_q == TO_LAST) begin
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    flush_d = flush_q + TO_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            period_q  <= '0;
            samples_q <= '0;
            mode_q    <= TRIG_IMMEDIATE;
            slot_q    <= '0;
            flush_q   <= '0;
            pend_q    <= 1'b0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            samples_q <= samples_d;
            mode_q    <= mode_d;
            slot_q    <= slot_d;
            flush_q   <= flush_d;
            pend_q    <= pend_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            aborted_q <= aborted_d;
            done_q    <= done_d;
        end
    end

    assign o_conv_req   = conv_req;
    assign o_armed      = (state_q == S_ARM);
    assign o_running    = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign o_done       = done_q;
    assign o_sample_idx = idx_q;
    assign o_overrun    = overrun_q;
    assign o_aborted    = aborted_q;

endmodule

// File: tb/tb_adc_capture_sched.sv
// Directed bench for adc_capture_sched with a time-based reference model.
module tb_adc_capture_sched;

    localparam int TB_MINP = 200;
    localparam int TB_TO   = 4096;
    localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_FLUSH = 3;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic [23:0] i_cfg_period = '0;
    logic [15:0] i_cfg_samples = '0;
    logic [1:0]  i_cfg_trig_mode = '0;
    logic        i_sw_trig = 1'b0;
    logic        i_external_trig = 1'b0;
    logic        i_conv_done = 1'b0;
    logic        o_conv_req, o_armed, o_running, o_done, o_overrun, o_aborted;
    logic [15:0] o_sample_idx;

    adc_capture_sched #(.P_MIN_PERIOD(TB_MINP), .P_DONE_TIMEOUT(TB_TO)) dut (
        .i_clk           (clk),
        .i_rst_n         (i_rst_n),
        .i_start         (i_start),
        .i_stop          (i_stop),
        .i_cfg_period    (i_cfg_period),
        .i_cfg_samples   (i_cfg_samples),
        .i_cfg_trig_mode (i_cfg_trig_mode),
        .i_sw_trig       (i_sw_trig),
        .i_external_trig (i_external_trig),
        .o_conv_req      (o_conv_req),
        .i_conv_done     (i_conv_done),
        .o_armed         (o_armed),
        .o_running       (o_running),
        .o_done          (o_done),
        .o_sample_idx    (o_sample_idx),
        .o_overrun       (o_overrun),
        .o_aborted       (o_aborted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
    endtask

    // Observed events, stamped with the clock edge that samples them.
    int req_edges[$];
    int done_edges[$];

    // Reference model: state of the capture expressed as elapsed time.
    int   mph = M_IDLE, per = TB_MINP, nsamp = 0, mmode = 0;
    int   rt = 0, fage = 0, midx = 0;
    bit   pend = 0, movr = 0, mabt = 0, mdone = 0, mvalid = 0, m_req = 0, trig = 0;
    logic [4:0] pinh = '0;

    always @(negedge clk) begin
        pinh = {pinh[3:0], (i_rst_n ? i_external_trig : 1'b0)};
        m_req = (mph == M_RUN) && !i_stop && ((rt % per) == 0) && (!pend || i_conv_done);
        if (mvalid) begin
            chk("conv_req",   o_conv_req,   m_req);
            chk("armed",      o_armed,      mph == M_ARM);
            chk("running",    o_running,    (mph == M_RUN) || (mph == M_FLUSH));
            chk("done",       o_done,       mdone);
            chk("sample_idx", o_sample_idx, midx);
            chk("overrun",    o_overrun,    movr);
            chk("aborted",    o_aborted,    mabt);
        end
        if (o_conv_req === 1'b1) req_edges.push_back(cyc + 1);
        if (o_done === 1'b1)     done_edges.push_back(cyc + 1);

        mdone = 0;
        if (!i_rst_n) begin
            mph = M_IDLE; midx = 0; movr = 0; mabt = 0; pend = 0; pinh = '0; mvalid = 1;
        end else begin
            case (mph)
                M_IDLE: if (i_start && !i_stop) begin
                    per   = (int'(i_cfg_period) < TB_MINP) ? TB_MINP : int'(i_cfg_period);
                    nsamp = int'(i_cfg_samples);
                    mmode = int'(i_cfg_trig_mode);
                    midx = 0; movr = 0; mabt = 0; pend = 0;
                    mph = M_ARM;
                end
                M_ARM: begin
                    case (mmode)
                        0: trig = 1;
                        1: trig = i_sw_trig;
                        2: trig = pinh[3] & ~pinh[4];
                        default: trig = ~pinh[3] & pinh[4];
                    endcase
                    if (i_stop) begin mph = M_IDLE; mabt = 1; end
                    else if (trig) begin mph = M_RUN; rt = 0; end
                end
                M_RUN: begin
                    if (i_conv_done) pend = 0;
                    if (i_stop) begin
                        mph = M_FLUSH; mabt = 1; fage = 0;
                    end else begin
                        if ((rt % per) == 0) begin
                            if (m_req) begin
                                midx = (midx + 1) % 65536;
                                pend = 1;
                                if (nsamp != 0 && midx == nsamp) begin mph = M_FLUSH; fage = 0; end
                            end else movr = 1;
                        end
                        rt++;
                    end
                end
                default: begin
                    if (!pend || i_conv_done) begin
                        mph = M_IDLE; mdone = 1; pend = 0;
                    end else begin
                        fage++;
                        if (fage == TB_TO) begin mph = M_IDLE; mdone = 1; mabt = 1; end
                    end
                end
            endcase
        end
    end

    // ADC driver stand-in: answers each request resp_delay clocks later.
    int resp_delay = 100;
    bit resp_en = 1;
    int rp = 0;
    always @(posedge clk) begin
        #2;
        i_conv_done = 1'b0;
        while (rp < req_edges.size() && req_edges[rp] + resp_delay <= cyc + 1) begin
            if (resp_en && req_edges[rp] + resp_delay == cyc + 1) i_conv_done = 1'b1;
            rp++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic do_start(input int p, input int ns, input int md, output int s);
        i_cfg_period = 24'(p); i_cfg_samples = 16'(ns); i_cfg_trig_mode = 2'(md);
        i_start = 1'b1; s = cyc + 1;
        tick(1);
        i_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while ((o_armed || o_running) && n < budget) begin tick(1); n++; end
        chk(nm, o_armed | o_running, 0);
        tick(2);
    endtask

    task automatic chk_req(input string nm, input int k, input int base, input int off);
        chk(nm, (k < req_edges.size()) ? req_edges[k] - base : -1, off);
    endtask

    task automatic chk_done(input string nm, input int k, input int base, input int off);
        chk(nm, (k < done_edges.size()) ? done_edges[k] - base : -1, off);
    endtask

    int s, t, r0, d0;

    initial begin
        tick(3);
        i_rst_n = 1'b1;
        tick(1);
        chk("rst_idx", o_sample_idx, 0);
        chk("rst_flags", {o_conv_req, o_armed, o_running, o_done, o_overrun, o_aborted}, 0);

        // Mode 0, period 500, 4 samples, done after 100 clocks.
        resp_en = 1; resp_delay = 100; r0 = req_edges.size(); d0 = done_edges.size();
        do_start(500, 4, 0, s);
        wait_idle(3000, "t1_timeout");
        chk_req("t1_req0", r0,     s, 2);
        chk_req("t1_req1", r0 + 1, s, 502);
        chk_req("t1_req2", r0 + 2, s, 1002);
        chk_req("t1_req3", r0 + 3, s, 1502);
        chk_done("t1_done", d0, s, 1603);
        chk("t1_idx", o_sample_idx, 4);
        chk("t1_ovr", o_overrun, 0);

        // Period below the floor is raised to 200.
        resp_delay = 50; r0 = req_edges.size();
        do_start(10, 2, 0, s);
        wait_idle(1000, "t2_timeout");
        chk_req("t2_req1", r0 + 1, s, 202);

        // Done coincides with the next slot: request still issues.
        resp_delay = 200; r0 = req_edges.size(); d0 = done_edges.size();
        do_start(200, 2, 0, s);
        wait_idle(1000, "t3_timeout");
        chk_req("t3_req1", r0 + 1, s, 202);
        chk_done("t3_done", d0, s, 403);
        chk("t3_ovr", o_overrun, 0);

        // Done withheld 1.5 periods: every other slot is skipped.
        resp_delay = 300; r0 = req_edges.size(); d0 = done_edges.size();
        do_start(200, 3, 0, s);
        tick(248);
        chk("t4_mid_idx", o_sample_idx, 1);
        chk("t4_mid_ovr", o_overrun, 1);
        wait_idle(2000, "t4_timeout");
        chk_req("t4_req1", r0 + 1, s, 402);
        chk_req("t4_req2", r0 + 2, s, 802);
        chk_done("t4_done", d0, s, 1103);
        chk("t4_idx", o_sample_idx, 3);

        // External rising trigger; a falling edge alone does nothing.
        resp_delay = 10; r0 = req_edges.size(); d0 = done_edges.size();
        i_external_trig = 1'b1;
        tick(10);
        do_start(200, 1, 2, s);
        tick(10);
        i_external_trig = 1'b0;
        tick(30);
        chk("t5_still_armed", o_armed, 1);
        tick(9);
        i_external_trig = 1'b1; t = cyc + 1;
        wait_idle(500, "t5_timeout");
        chk_req("t5_req0", r0, t, 4);
        chk_done("t5_done", d0, t, 15);
        i_external_trig = 1'b0;

        // Stop while armed: back to idle, aborted, no done.
        d0 = done_edges.size();
        do_start(200, 0, 1, s);
        tick(3);
        i_stop = 1'b1; tick(1); i_stop = 1'b0;
        tick(3);
        chk("t6_armed", o_armed, 0);
        chk("t6_aborted", o_aborted, 1);
        chk("t6_no_done", done_edges.size() - d0, 0);

        // Software trigger.
        r0 = req_edges.size();
        do_start(200, 1, 1, s);
        tick(5);
        i_sw_trig = 1'b1; t = cyc + 1; tick(1); i_sw_trig = 1'b0;
        wait_idle(500, "t7_timeout");
        chk_req("t7_req0", r0, t, 1);
        chk("t7_aborted", o_aborted, 0);

        // Start together with stop in idle is ignored.
        i_start = 1'b1; i_stop = 1'b1; tick(1); i_start = 1'b0; i_stop = 1'b0;
        tick(2);
        chk("t8_armed", o_armed, 0);

        // Stop in RUN with the conversion never completing: FLUSH times out.
        resp_en = 0; d0 = done_edges.size();
        do_start(200, 0, 0, s);
        tick(48);
        i_stop = 1'b1; t = cyc + 1; tick(1); i_stop = 1'b0;
        wait_idle(5000, "t9_timeout");
        chk_done("t9_done", d0, t, TB_TO + 1);
        chk("t9_aborted", o_aborted, 1);

        // Reset in the middle of a capture.
        resp_en = 1; resp_delay = 100; d0 = done_edges.size();
        do_start(300, 0, 0, s);
        tick(100);
        chk("t10_running", o_running, 1);
        i_rst_n = 1'b0; tick(1);
        chk("t10_idx", o_sample_idx, 0);
        chk("t10_flags", {o_conv_req, o_armed, o_running, o_done, o_overrun, o_aborted}, 0);
        i_rst_n = 1'b1;
        tick(20);
        chk("t10_no_done", done_edges.size() - d0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

endmodule
